// File: rtl/fetch_unit.sv
// fetch_unit -- in-order instruction fetch front end.
//
// Issues sequential word-aligned fetch requests to instruction memory,
// tags each outstanding request with its PC, and collects the in-order
// responses into a DEPTH-entry instruction FIFO presented to decode.
// A redirect reloads the fetch PC, flushes the FIFO and arranges for
// every response still in flight to be discarded on arrival.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries and max requests in flight (2..8)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order fetch response channel
//   redirect_valid/redirect_pc      taken branch/jump from execute
//   instr_valid/ready, instr,       FIFO head toward decode
//   instr_pc
//   fetch_misalign                  (only with FETCH_MISALIGN_CHECK_EN)
//                                   one-cycle pulse after a redirect
//                                   whose target had nonzero low bits
//
// Configuration macro: FETCH_MISALIGN_CHECK_EN
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } buf_entry_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // fetch PC (also the presented request address)
    logic [31:0]             pc_q, pc_d;
    // os counts every request in flight, stale ones included; drop is
    // the subset (always the oldest) that must be discarded on arrival
    logic [CW-1:0]           os_q, os_d;
    logic [CW-1:0]           drop_q, drop_d;
    // PC tags of live (non-dropped) requests, oldest at tag_rd
    logic [DEPTH-1:0][31:0]  tag_q, tag_d;
    logic [PW-1:0]           tag_wr_q, tag_wr_d;
    logic [PW-1:0]           tag_rd_q, tag_rd_d;
    // instruction FIFO
    buf_entry_t [DEPTH-1:0]  buf_q, buf_d;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [CW-1:0]           occ;
    logic                    req_hs;
    logic                    rsp_keep;
    logic                    pop;

    // Counting in-flight requests together with buffered ones guarantees
    // every response has a FIFO slot, so a push never meets a full FIFO.
    // Since occ can only rise through a handshake, a pending request
    // cannot be withdrawn except by a redirect.
    assign occ            = os_q + cnt_q;
    assign imem_req_valid = rst_n && !redirect_valid && (occ < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (cnt_q != '0);
    assign instr          = instr_valid ? buf_q[head_q].data : '0;
    assign instr_pc       = instr_valid ? buf_q[head_q].pc   : '0;

    always_comb begin
        req_hs   = imem_req_valid && imem_req_ready;
        // in a redirect cycle every in-flight request is already stale
        rsp_keep = imem_rsp_valid && !redirect_valid && (drop_q == '0);
        pop      = instr_valid && instr_ready && !redirect_valid;

        pc_d     = pc_q;
        os_d     = os_q + CW'(req_hs) - CW'(imem_rsp_valid);
        drop_d   = drop_q;
        tag_d    = tag_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        buf_d    = buf_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q + CW'(rsp_keep) - CW'(pop);

        if (req_hs) begin
            pc_d            = pc_q + 32'd4;
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = ptr_inc(tag_wr_q);
        end

        if (rsp_keep) begin
            buf_d[tail_q].pc   = tag_q[tag_rd_q];
            buf_d[tail_q].data = imem_rsp_data;
            tail_d             = ptr_inc(tail_q);
            tag_rd_d           = ptr_inc(tag_rd_q);
        end else if (imem_rsp_valid && !redirect_valid) begin
            drop_d = drop_q - CW'(1);
        end

        if (pop) head_d = ptr_inc(head_q);

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            // everything in flight becomes stale; a response arriving
            // right now is consumed by this same cycle
            drop_d   = os_q - CW'(imem_rsp_valid);
            tag_wr_d = '0;
            tag_rd_d = '0;
            head_d   = '0;
            tail_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            os_q     <= '0;
            drop_q   <= '0;
            tag_q    <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            buf_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            os_q     <= os_d;
            drop_q   <= drop_d;
            tag_q    <= tag_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            buf_q    <= buf_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_misalign_q, fetch_misalign_d;

    always_comb begin
        fetch_misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_misalign_q <= 1'b0;
        else        fetch_misalign_q <= fetch_misalign_d;
    end

    assign fetch_misalign = fetch_misalign_q;
`else
    // low target bits are dropped silently in this build
    logic misalign_unused;
    assign misalign_unused = |redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Reference model: an in-order memory queue whose entries carry the
// redirect epoch they were issued in, plus a queue of PCs waiting for
// decode. A response is kept only if its epoch is current and it does
// not arrive in a redirect cycle.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] hs_addr[$];
    int          epoch, cyc, total, bad;
    int          n_req, n_pop;
    logic [31:0] exp_req_pc, last_pop_pc, obs_addr, obs_ipc;
    bit          exp_req_valid, exp_mis, obs_valid, obs_iv;
    int          p_ready, p_iready, p_redir, lat_min, lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_req_valid = !redirect_valid && (mem_q.size() + pend_q.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
        chk("req_addr", imem_req_addr, exp_req_pc);
        chk("instr_valid", 32'(instr_valid), 32'(pend_q.size() != 0));
        if (pend_q.size() != 0) begin
            chk("instr_pc", instr_pc, pend_q[0]);
            chk("instr", instr, mem_word(pend_q[0]));
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign", 32'(fetch_misalign), 32'(exp_mis));
`endif
        obs_addr  = imem_req_addr;
        obs_ipc   = instr_pc;
        obs_valid = imem_req_valid;
        obs_iv    = instr_valid;
    endtask

    task automatic update_model();
        mreq_t e;
        if (pend_q.size() != 0 && instr_ready && !redirect_valid) void'(pend_q.pop_front());
        if (obs_iv && instr_ready && !redirect_valid) begin
            last_pop_pc = obs_ipc;
            n_pop++;
        end
        if (imem_rsp_valid && mem_q.size() != 0) begin
            e = mem_q.pop_front();
            if (!redirect_valid && e.epoch == epoch) pend_q.push_back(e.addr);
        end
        if (exp_req_valid && imem_req_ready) begin
            e.addr  = exp_req_pc;
            e.epoch = epoch;
            e.due   = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(e);
            exp_req_pc += 32'd4;
        end
        if (obs_valid && imem_req_ready) begin
            hs_addr.push_back(obs_addr);
            n_req++;
        end
        if (redirect_valid) begin
            pend_q.delete();
            epoch++;
            exp_req_pc = {redirect_pc[31:2], 2'b00};
        end
        exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        cyc++;
    endtask

    task automatic drive();
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_iready);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom();
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
        mem_q.delete();
        pend_q.delete();
        exp_req_pc = RESET_PC;
        exp_mis    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive();
    endtask

    task automatic wait_pop(input string tag);
        int p0;
        p0 = n_pop;
        for (int i = 0; i < 30 && n_pop == p0; i++) cycle();
        chk(tag, 32'(n_pop > p0), 32'd1);
    endtask

    initial begin
        logic [31:0] a0, h0, h1;
        int n0;
        total = 0; bad = 0; epoch = 0; cyc = 0; n_req = 0; n_pop = 0;
        last_pop_pc = '0;

        // streaming from reset: 1-cycle memory, always ready
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        do_reset();
        wait_pop("stream_first_pop");
        chk("stream_first_pc", last_pop_pc, RESET_PC);
        repeat (12) cycle();

        // decode stalled for 10 cycles: exactly DEPTH requests go out
        p_iready = 0;
        do_reset();
        n0 = n_req;
        repeat (10) cycle();
        chk("stall_nreq", 32'(n_req - n0), 32'(DEPTH));
        chk("stall_noreq", 32'(imem_req_valid), 32'd0);
        p_iready = 100; instr_ready = 1'b1;
        cycle();
        chk("drain_first_pc", last_pop_pc, RESET_PC);
        repeat (8) cycle();

        // two requests in flight at 3-cycle latency, then redirect
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 10 && mem_q.size() != 2; i++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        chk("redir_ivalid_after", 32'(instr_valid), 32'd0);
        wait_pop("redir_pop");
        chk("redir_pc", last_pop_pc, 32'h0000_0100);

        // memory not ready for 4 cycles: address held
        p_ready = 0; imem_req_ready = 1'b0;
        a0 = imem_req_addr;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("hold_addr", obs_addr, a0);
        end
        p_ready = 100; imem_req_ready = 1'b1;
        cycle();
        chk("hold_adv", imem_req_addr, a0 + 32'd4);

        // wrap at top of address space
        lat_min = 1; lat_max = 2;
        repeat (4) cycle();
        hs_addr.delete();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        for (int i = 0; i < 20 && hs_addr.size() < 2; i++) cycle();
        h0 = (hs_addr.size() > 0) ? hs_addr[0] : 32'hxxxx_xxxx;
        h1 = (hs_addr.size() > 1) ? hs_addr[1] : 32'hxxxx_xxxx;
        chk("wrap_a0", h0, 32'hFFFF_FFFC);
        chk("wrap_a1", h1, 32'h0000_0000);
        repeat (6) cycle();

        // chained redirects with stale traffic in flight
        lat_min = 3; lat_max = 3;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        cycle();
        wait_pop("b2b_pop");
        chk("b2b_pc", last_pop_pc, 32'h0000_0400);

        // misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_pulse", 32'(fetch_misalign), 32'd1);
`endif
        chk("mis_addr", imem_req_addr, 32'h0000_0100);
        cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_clear", 32'(fetch_misalign), 32'd0);
`endif
        wait_pop("mis_pop");
        chk("mis_pc", last_pop_pc, 32'h0000_0100);

        // random traffic, with a reset in the middle
        p_ready = 70; p_iready = 60; p_redir = 8; lat_min = 1; lat_max = 4;
        repeat (300) cycle();
        do_reset();
        p_redir = 20;
        repeat (200) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, legal range 2..8: instruction buffer entries and the maximum number of outstanding memory requests.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1: memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 32: word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1: response valid; responses return in request order with latency of at least 1 cycle.
REQ-009 SHALL have port imem_rsp_data, input, 32: fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1: branch/jump taken, from execute.
REQ-011 SHALL have port redirect_pc, input, 32: new fetch target.
REQ-012 SHALL have port instr_valid, output, 1: buffer head valid toward decode/immediate generation.
REQ-013 SHALL have port instr_ready, input, 1: decode consumes the head.
REQ-014 SHALL have port instr, output, 32: head instruction word.
REQ-015 SHALL have port instr_pc, output, 32: address of the head instruction.

Function
REQ-016 SHALL hold fetch PC; on request handshake (valid && ready) the PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 SHALL assert imem_req_valid only when outstanding + buffer occupancy < DEPTH and redirect_valid is low.
REQ-018 While imem_req_valid is high and imem_req_ready is low, imem_req_addr SHALL be held stable; only a redirect may withdraw the request.
REQ-019 SHALL keep an in-order PC tag per outstanding request; each accepted response SHALL be written to the buffer with its tag.
REQ-020 Buffer SHALL be a FIFO; instr/instr_pc SHALL show the head; pop on instr_valid && instr_ready.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; a push while full SHALL never occur, by REQ-017.
REQ-022 Minimum latency: request accepted in cycle N, response in N+1 -> instr_valid high in N+2.
REQ-023 On redirect_valid: fetch PC <= redirect_pc{[31:2],2'b00} at the next edge; the buffer SHALL be flushed; the current outstanding count SHALL be loaded into a drop counter.
REQ-024 Responses arriving while the drop counter is non-zero, including in the redirect cycle itself, SHALL be discarded and decrement the counter.
REQ-025 instr_valid SHALL be low in the cycle after a redirect; a pop request in the redirect cycle SHALL be ignored.
REQ-026 A redirect with an empty buffer and no outstanding requests SHALL take effect with no dropped responses.
REQ-027 Back-to-back redirects SHALL each reload PC; the drop counter SHALL accumulate all then-outstanding requests.

Reset
REQ-028 On rst_n low, regardless of clk: fetch PC = RESET_PC; buffer empty; outstanding = 0; drop counter = 0.
REQ-029 During reset: imem_req_valid = 0, instr_valid = 0, imem_req_addr = RESET_PC, instr = 0, instr_pc = 0.
REQ-030 Fetching SHALL start from the first rising clk edge after rst_n deasserts.
REQ-031 Reset mid-operation SHALL abandon all outstanding requests; late responses after reset SHALL be ignored only while drop accounting permits, so the memory SHALL be reset together with this block.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN: when defined, the block SHALL add output port fetch_misalign (1 bit), which is registered and pulses for one cycle when redirect_valid is high and redirect_pc[1:0] != 0; the PC SHALL still be loaded with the low two bits cleared.
REQ-033 Without FETCH_MISALIGN_CHECK_EN, port fetch_misalign SHALL be absent and the low two bits of redirect_pc SHALL be silently cleared.

Verification
REQ-034 Reset then imem_req_ready=1, 1-cycle memory, instr_ready=1 -> addresses 0,4,8,... and instr_pc follows the same sequence with each matching instr.
REQ-035 instr_ready=0 for 10 cycles -> exactly DEPTH requests issued, then imem_req_valid stays 0; no instruction lost when instr_ready returns high.
REQ-036 2 requests outstanding, 3-cycle latency, redirect_pc=32'h100 -> both stale responses dropped; next instr_pc = 32'h100.
REQ-037 imem_req_ready held 0 for 4 cycles -> imem_req_addr stable across those cycles; PC advances only once ready rises.
REQ-038 Redirect to 32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC then 32'h0000_0000.
REQ-039 With FETCH_MISALIGN_CHECK_EN defined, redirect_pc=32'h102 -> fetch_misalign pulses for one cycle and the next fetch address is 32'h100.
